// File: rtl/nios_system_sprite_sequencer.sv
// nios_system_sprite_sequencer: Avalon-MM frame-locked sprite animation scheduler.
// Optional ping-pong stepping is enabled by defining SPRITE_SEQ_PINGPONG_EN.
module nios_system_sprite_sequencer #(
  parameter int PERIOD_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        frame_tick,
  output logic [1:0]  out_port,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state;
  logic ctrl_run, ctrl_oneshot, ctrl_irq_en, done, tick_q, frame_edge, wr, step_hit, pp_bit;
  logic [PERIOD_W-1:0] period, counter, eff_period;
  logic [1:0] first, last, next_sprite;
  logic unused_wd;
  assign unused_wd = ^writedata;
  assign wr = chipselect & ~write_n;
  assign frame_edge = frame_tick & ~tick_q;
`ifdef SPRITE_SEQ_PINGPONG_EN
  logic ctrl_pingpong, dir_up, at_end, pp_active;
  assign pp_bit = ctrl_pingpong;
  assign pp_active = ctrl_pingpong & ~ctrl_oneshot;
  assign at_end = dir_up ? (out_port == last) : (out_port == first);
`else
  assign pp_bit = 1'b0;
`endif
  always_comb begin
    eff_period = (period == '0) ? PERIOD_W'(1) : period;
    step_hit = ({1'b0, counter} + 1'b1) >= {1'b0, eff_period};
`ifdef SPRITE_SEQ_PINGPONG_EN
    // Moving up and reaching LAST (or down and reaching FIRST) reverses before stepping.
    next_sprite = !pp_active ? ((out_port == last) ? first : out_port + 2'd1) :
                  (first == last) ? out_port :
                  (dir_up ^ at_end) ? out_port + 2'd1 : out_port - 2'd1;
`else
    next_sprite = (out_port == last) ? first : out_port + 2'd1;
`endif
    readdata = (address == 2'd0) ? {28'b0, pp_bit, ctrl_irq_en, ctrl_oneshot, ctrl_run} :
               (address == 2'd1) ? {{(32-PERIOD_W){1'b0}}, period} :
               (address == 2'd2) ? {28'b0, last, first} :
                                   {27'b0, done, state, out_port};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      done         <= 1'b0;
      counter      <= '0;
      tick_q       <= 1'b0;
      out_port     <= 2'd0;
      irq          <= 1'b0;
      ctrl_run     <= 1'b0;
      ctrl_oneshot <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      period       <= PERIOD_W'(1);
      first        <= 2'd0;
      last         <= 2'd3;
`ifdef SPRITE_SEQ_PINGPONG_EN
      ctrl_pingpong <= 1'b0;
      dir_up        <= 1'b1;
`endif
    end else begin
      tick_q <= frame_tick;
      irq    <= done & ctrl_irq_en;
      if (wr && address == 2'd1) period <= writedata[PERIOD_W-1:0];
      if (wr && address == 2'd2) {last, first} <= writedata[3:0];
      if (wr && address == 2'd3 && state != RUN) out_port <= writedata[1:0];
      // A CTRL write takes priority over a coincident frame edge.
      if (wr && address == 2'd0) begin
        {ctrl_irq_en, ctrl_oneshot, ctrl_run} <= writedata[2:0];
`ifdef SPRITE_SEQ_PINGPONG_EN
        ctrl_pingpong <= writedata[3];
        if (writedata[0]) dir_up <= 1'b1;
`endif
        done <= 1'b0;
        if (writedata[0]) begin
          state    <= RUN;
          out_port <= first;
          counter  <= '0;
        end else begin
          state <= IDLE;
        end
      end else if (state == RUN && frame_edge) begin
        if (!step_hit) begin
          counter <= counter + 1'b1;
        end else begin
          counter <= '0;
          if (ctrl_oneshot && out_port == last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            out_port <= next_sprite;
`ifdef SPRITE_SEQ_PINGPONG_EN
            if (pp_active && first != last && at_end) dir_up <= ~dir_up;
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_nios_system_sprite_sequencer.sv
// tb_nios_system_sprite_sequencer: directed self-checking bench for the sprite sequencer.
module tb_nios_system_sprite_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        frame_tick = 1'b0;
  logic [1:0]  out_port;
  logic        irq;
  int checks = 0;
  int errors = 0;

  nios_system_sprite_sequencer #(.PERIOD_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .frame_tick(frame_tick), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp [4] = '{32'h0, 32'h1, 32'hC, 32'h0};
    reset_n = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      checks++;
      if (d !== exp[i]) begin errors++; $display("FAIL reset_read%0d: got %h expected %h", i, d, exp[i]); end
    end
    checks++;
    if (out_port !== 2'd0) begin errors++; $display("FAIL reset_out_port: got %0d expected 0", out_port); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp [9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    wr(1, 2); wr(2, 32'hC); wr(0, 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (out_port !== exp[i]) begin errors++; $display("FAIL wrap_step%0d: got %0d expected %0d", i, out_port, exp[i]); end
    end
    wr(0, 0);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(2, 32'h7); wr(1, 1); wr(0, 7);
    checks++;
    if (out_port !== 2'd3) begin errors++; $display("FAIL oneshot_start: got %0d expected 3", out_port); end
    tick();
    checks++;
    if (out_port !== 2'd0) begin errors++; $display("FAIL oneshot_step1: got %0d expected 0", out_port); end
    tick();
    checks++;
    if (out_port !== 2'd1) begin errors++; $display("FAIL oneshot_step2: got %0d expected 1", out_port); end
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    rd(3, d);
    checks++;
    if (d !== 32'h19) begin errors++; $display("FAIL oneshot_done_status: got %h expected 19", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_lag: got %b expected 0", irq); end
    cyc();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq: got %b expected 1", irq); end
    tick(); tick();
    checks++;
    if (out_port !== 2'd1) begin errors++; $display("FAIL oneshot_hold: got %0d expected 1", out_port); end
    wr(0, 0);
    rd(3, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL oneshot_clear_status: got %h expected 1", d); end
    cyc();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_drop: got %b expected 0", irq); end
  endtask

  task automatic test_sprite_force();
    wr(2, 32'hC); wr(1, 1); wr(0, 1);
    tick();
    wr(3, 2);
    checks++;
    if (out_port !== 2'd1) begin errors++; $display("FAIL force_in_run: got %0d expected 1", out_port); end
    wr(0, 0);
    wr(3, 2);
    checks++;
    if (out_port !== 2'd2) begin errors++; $display("FAIL force_in_idle: got %0d expected 2", out_port); end
    tick();
    checks++;
    if (out_port !== 2'd2) begin errors++; $display("FAIL idle_ignores_tick: got %0d expected 2", out_port); end
  endtask

  task automatic test_write_edge();
    wr(1, 0); wr(2, 32'hC); wr(0, 1);
    tick(); tick();
    checks++;
    if (out_port !== 2'd2) begin errors++; $display("FAIL period0_steps: got %0d expected 2", out_port); end
    address = 2'd0; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0; frame_tick = 1'b1;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; frame_tick = 1'b0;
    cyc();
    checks++;
    if (out_port !== 2'd0) begin errors++; $display("FAIL write_beats_edge: got %0d expected 0", out_port); end
    tick();
    checks++;
    if (out_port !== 2'd1) begin errors++; $display("FAIL after_write_edge: got %0d expected 1", out_port); end
  endtask

  task automatic test_period_change();
    logic [31:0] d;
    wr(0, 0); wr(1, 4); wr(0, 1);
    tick(); tick();
    checks++;
    if (out_port !== 2'd0) begin errors++; $display("FAIL period4_hold: got %0d expected 0", out_port); end
    wr(1, 32'h1FF);
    rd(1, d);
    checks++;
    if (d !== 32'hFF) begin errors++; $display("FAIL period_readback: got %h expected ff", d); end
    wr(1, 1);
    tick();
    checks++;
    if (out_port !== 2'd1) begin errors++; $display("FAIL period_shrink_step: got %0d expected 1", out_port); end
  endtask

  task automatic test_pingpong();
    logic [31:0] d;
`ifdef SPRITE_SEQ_PINGPONG_EN
    logic [1:0] exp [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    logic [31:0] ctrl_exp = 32'h9;
`else
    logic [1:0] exp [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] ctrl_exp = 32'h1;
`endif
    wr(0, 0); wr(1, 1); wr(2, 32'hC); wr(0, 9);
    rd(0, d);
    checks++;
    if (d !== ctrl_exp) begin errors++; $display("FAIL pp_ctrl_read: got %h expected %h", d, ctrl_exp); end
    checks++;
    if (out_port !== 2'd0) begin errors++; $display("FAIL pp_start: got %0d expected 0", out_port); end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (out_port !== exp[i]) begin errors++; $display("FAIL pp_step%0d: got %0d expected %0d", i, out_port, exp[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(0, 1); tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 2'd0) begin errors++; $display("FAIL async_reset_out: got %0d expected 0", out_port); end
    rd(0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_reset_ctrl: got %h expected 0", d); end
    rd(3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL async_reset_status: got %h expected 0", d); end
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_oneshot();
    test_sprite_force();
    test_write_edge();
    test_period_change();
    test_pingpong();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nios_system_sprite_sequencer.md
# nios_system_sprite_sequencer

Avalon-MM slave that sequences the 2-bit sprite number driven to the sprite renderer. It replaces a plain software-written sprite register with a frame-locked animation scheduler. Software programs the sprite range, the frames-per-step period and the mode; the block then steps `out_port` on frame ticks from the VGA controller. A done interrupt marks the end of one-shot animations.

## Interface
Parameters:
- `PERIOD_W`, 8, width of the frames-per-step register and frame counter.

Ports:
- `clk` in 1 – system clock.
- `reset_n` in 1 – reset; one clock; reset is asynchronous and active-low.
- `address` in 2 – register select.
- `chipselect` in 1 – slave select.
- `write_n` in 1 – active-low write strobe; a write is `chipselect && !write_n`.
- `writedata` in 32 – write data.
- `readdata` out 32 – combinational read data for `address`; unused bits are 0.
- `frame_tick` in 1 – vsync-derived level, synchronous to `clk`; only its rising edge is used.
- `out_port` out 2 – current sprite number, registered.
- `irq` out 1 – `done & irq_en`, registered.

## Operation
Register map:
- addr 0 CTRL (R/W): bit0 `run`, bit1 `oneshot`, bit2 `irq_en`.
  - A write with `run`=1 loads sprite←FIRST, clears the frame counter and `done`, and enters RUN.
  - A write with `run`=0 enters IDLE and clears `done`.
- addr 1 PERIOD (R/W): bits[PERIOD_W-1:0] set frames per step. Value 0 behaves as 1.
- addr 2 RANGE (R/W): bits[1:0] FIRST, bits[3:2] LAST.
- addr 3 SPRITE (R/W):
  - Read returns {27'b0, done, state[1:0], sprite[1:0]}.
  - Write of bits[1:0] forces the sprite only in IDLE or DONE. It is ignored in RUN.

State machine (state encoding: IDLE=0, RUN=1, DONE=2):
- IDLE: sprite holds; frame edges are ignored.
- RUN: on each frame edge the frame counter increments. When counter+1 ≥ max(PERIOD,1), the counter clears and the sprite steps.
  - Step, normal: if sprite==LAST, the next sprite is FIRST; otherwise sprite+1 mod 4. FIRST>LAST therefore wraps through 3→0.
  - oneshot: if sprite==LAST at a step, the sprite holds, `done`←1, and the state goes to DONE.
- DONE: sprite holds. Leave only by a CTRL write.
- FIRST==LAST: the sprite is constant. In oneshot, `done` sets at the first step.
- The CTRL bit0 read value reflects the stored bit, not the state. The state is readable at addr 3.
- Frame edge: `edge = frame_tick & ~tick_q`, where `tick_q` is `frame_tick` registered. `tick_q` resets to 0.

## Timing
- Reset values:
  - out_port=0, irq=0, state=IDLE, done=0, counter=0, tick_q=0.
  - CTRL=0, PERIOD=1, RANGE=0x0C (FIRST=0, LAST=3).
- Register writes take effect at the next `clk` edge. `readdata` is valid in the same cycle as `address`, with no wait states.
- A `frame_tick` rising at cycle n is detected in cycle n. `out_port` updates at the edge ending cycle n, so it is visible in cycle n+1.
- `irq` rises one cycle after `done` sets and falls one cycle after `done` clears.
- A CTRL write in the same cycle as a frame edge: the write wins and the edge is discarded.
- Writes to PERIOD or RANGE during RUN do not restart the sequence. They apply from the next frame edge.
  - If the counter is already ≥ the new PERIOD, the next edge steps.
- Reset asserted mid-sequence returns all state to reset values immediately (asynchronous).

## Configuration
- `SPRITE_SEQ_PINGPONG_EN`: adds CTRL bit3 `pingpong` and an internal direction flag. The flag resets to up and is set to up on a CTRL run write.
  - With `pingpong`=1 and not oneshot, the sprite moves FIRST→LAST, then reverses LAST→FIRST, and repeats. Ends are not repeated.
  - The down step is sprite−1 mod 4.
- Without the macro: CTRL bit3 reads 0 and writes to it are ignored; behaviour is wrap-only.

## Test plan
- Reset, then read all four addresses -> 0x0, 0x1, 0xC, 0x0; out_port=0, irq=0.
- PERIOD=2, RANGE=0xC, CTRL=0x1, then 9 tick pulses -> out_port after each pulse: 0,1,1,2,2,3,3,0,0.
- RANGE={LAST=1,FIRST=3}=0x7, PERIOD=1, CTRL=0x7 (run+oneshot+irq_en) -> out_port 3,0,1.
  - Then done=1 and state=DONE.
  - irq is 1 the cycle after; further ticks leave out_port at 1.
  - A CTRL=0 write drops irq within 1 cycle.
- In RUN, write SPRITE=2 -> ignored (out_port unchanged). In IDLE, write SPRITE=2 -> out_port=2 next cycle.
- PERIOD=0, RANGE=0xC, run, with a CTRL run write in the same cycle as a tick edge -> sprite=FIRST=0, counter=0, and that edge does not step. The next tick steps to 1.
- With `SPRITE_SEQ_PINGPONG_EN` defined, CTRL=0x9, RANGE=0xC, PERIOD=1 -> 0,1,2,3,2,1,0,1. Without the macro -> wrap sequence 0,1,2,3,0,1,2,3.
